// File: rtl/lms_pkg.sv
// Package for the LMS weight-update engine.
//   state_e    : engine sequencing states
//   sat_t      : clamped value plus clamp flag returned by sat()
//   prod_shift : right shift taking a Q(2*FRAC) product to Q(COEFF_FRAC+1),
//                which folds the factor of two of 2*mu*e*x into the shift
//   sat()      : clamp a signed value to a signed field of the given width
package lms_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScale,
    StUpdate,
    StDrain
  } state_e;

  typedef struct packed {
    logic signed [63:0] val;
    logic               clamp;
  } sat_t;

  function automatic int unsigned prod_shift(input int unsigned frac,
                                             input int unsigned coeff_frac);
    return 2 * frac - coeff_frac - 1;
  endfunction

  // Shift for the default number formats (FRAC=12, COEFF_FRAC=14).
  localparam int unsigned PROD_SHIFT = prod_shift(12, 14);

  // Clamp to [-2^(width-1), 2^(width-1)-1]; clamp flag is set when limited.
  function automatic sat_t sat(input logic signed [63:0] value, input int unsigned width);
    sat_t               r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    r.val   = value;
    r.clamp = 1'b0;
    if (value > hi) begin
      r.val   = hi;
      r.clamp = 1'b1;
    end else if (value < lo) begin
      r.val   = lo;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lms_fx_mul.sv
// Registered signed WIDTH x WIDTH multiplier, shared by the scale and tap-update phases.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, clears the product register
//   a,b : signed operands
//   p   : full-precision signed product, registered (one cycle latency)
module lms_fx_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/lms_update_engine.sv
// Time-multiplexed LMS weight-update engine: w[k] += 2*mu*e*x[k] over TAPS taps using a single
// registered multiplier. All intermediate results saturate; any clamp sets the sticky o_sat.
// Timeline from accept (cycle 0): SCALE at 1, taps issued 2..TAPS+1, last write visible at
// TAPS+3, o_done pulse with o_ready at TAPS+4.
// Optional build macro: LMS_LEAK_EN adds leakage w - (w >>> LEAK_SHIFT) in the tap update.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_valid / o_ready    update request handshake (o_ready = idle and not loading)
//   i_error, i_step_size error e and step mu, signed Q(FRAC)
//   i_din                tap vector, x[k] at bits [k*WIDTH +: WIDTH]
//   i_load               load i_load_weights into the bank (idle only, wins over i_valid)
//   i_load_weights       weights to load, w[k] at bits [k*COEFF_WIDTH +: COEFF_WIDTH]
//   o_weights            current weight bank, same packing
//   o_done               one-cycle pulse at update completion
//   o_sat                sticky clamp flag, cleared on accept
module lms_update_engine
  import lms_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC        = 12,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned COEFF_FRAC  = 14,
  parameter int unsigned TAPS        = 4,
  parameter int unsigned LEAK_SHIFT  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WIDTH-1:0]              i_error,
  input  logic [WIDTH-1:0]              i_step_size,
  input  logic [TAPS*WIDTH-1:0]         i_din,
  input  logic                          i_load,
  input  logic [TAPS*COEFF_WIDTH-1:0]   i_load_weights,
  output logic [TAPS*COEFF_WIDTH-1:0]   o_weights,
  output logic                          o_done,
  output logic                          o_sat
);

  localparam int unsigned ProdShift = prod_shift(FRAC, COEFF_FRAC);
  localparam int unsigned IdxW      = (TAPS > 1) ? $clog2(TAPS) : 1;

  if (2 * FRAC < COEFF_FRAC + 1 || TAPS < 1 || LEAK_SHIFT >= 64) begin : g_param_check
    $error("lms_update_engine: unsupported parameter combination");
  end

  state_e                        state_q, state_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic                          drain_q, drain_d;
  logic                          accept;
  logic signed [WIDTH-1:0]       err_q, mu_q, mu_e_q;
  logic [TAPS*WIDTH-1:0]         din_q;
  logic signed [COEFF_WIDTH-1:0] w_q [TAPS];
  logic                          s1_valid_q;
  logic [IdxW-1:0]               s1_idx_q;
  logic                          done_q, sat_q;

  logic signed [WIDTH-1:0]       mul_a, mul_b;
  logic signed [2*WIDTH-1:0]     mul_p;
  logic signed [63:0]            mul_p_ext, cur_w_ext, sum_v;
  sat_t                          mu_e_r, off_r, new_r;
  logic signed [WIDTH-1:0]       mu_e_now;
  logic                          issue, first_tap, sat_hit;
  int unsigned                   tap_lsb;

  // Sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_valid && !i_load) begin
          accept  = 1'b1;
          state_d = StScale;
        end
      end
      StScale: begin
        state_d = StUpdate;
        idx_d   = '0;
      end
      StUpdate: begin
        if (idx_q == IdxW'(TAPS - 1)) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q) begin
          state_d = StIdle;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign issue     = (state_q == StUpdate);
  assign first_tap = issue && (idx_q == '0);

  // Datapath. On the first tap cycle the multiplier output still holds mu*e, so mu_e is taken
  // straight from it and also captured for the remaining taps.
  always_comb begin
    mul_p_ext = 64'(mul_p);
    mu_e_r    = sat(mul_p_ext >>> FRAC, WIDTH);
    mu_e_now  = WIDTH'(mu_e_r.val);
    off_r     = sat(mul_p_ext >>> ProdShift, COEFF_WIDTH);
    cur_w_ext = 64'(w_q[s1_idx_q]);
`ifdef LMS_LEAK_EN
    sum_v     = cur_w_ext - (cur_w_ext >>> LEAK_SHIFT) + off_r.val;
`else
    sum_v     = cur_w_ext + off_r.val;
`endif
    new_r     = sat(sum_v, COEFF_WIDTH);
    tap_lsb   = 32'(idx_q) * WIDTH;
    mul_a     = '0;
    mul_b     = '0;
    if (state_q == StScale) begin
      mul_a = mu_q;
      mul_b = err_q;
    end else if (issue) begin
      mul_a = $signed(din_q[tap_lsb +: WIDTH]);
      mul_b = first_tap ? mu_e_now : mu_e_q;
    end
    sat_hit = (first_tap && mu_e_r.clamp) || (s1_valid_q && (off_r.clamp || new_r.clamp));
  end

  lms_fx_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk(i_clk),
    .rst(i_rst),
    .a  (mul_a),
    .b  (mul_b),
    .p  (mul_p)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      err_q      <= '0;
      mu_q       <= '0;
      din_q      <= '0;
      mu_e_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      s1_valid_q <= issue;
      s1_idx_q   <= idx_q;
      done_q     <= (state_q == StDrain) && drain_q;
      if (accept) begin
        err_q <= $signed(i_error);
        mu_q  <= $signed(i_step_size);
        din_q <= i_din;
      end
      if (first_tap) begin
        mu_e_q <= mu_e_now;
      end
      if (accept) begin
        sat_q <= 1'b0;
      end else if (sat_hit) begin
        sat_q <= 1'b1;
      end
    end
  end

  // Weight bank: load only while idle; stage-2 writes only occur outside idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) begin
        w_q[k] <= '0;
      end
    end else if (state_q == StIdle && i_load) begin
      for (int k = 0; k < TAPS; k++) begin
        w_q[k] <= $signed(i_load_weights[k*COEFF_WIDTH +: COEFF_WIDTH]);
      end
    end else if (s1_valid_q) begin
      w_q[s1_idx_q] <= COEFF_WIDTH'(new_r.val);
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_weights_out
    assign o_weights[k*COEFF_WIDTH +: COEFF_WIDTH] = w_q[k];
  end

  assign o_ready = (state_q == StIdle) && !i_load;
  assign o_done  = done_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_lms_update_engine.sv
// Self-checking bench for lms_update_engine (WIDTH=16, FRAC=12, COEFF_WIDTH=18, COEFF_FRAC=14,
// TAPS=4, LEAK_SHIFT=4). The reference model applies w[k] += 2*mu*e*x[k] with floor division
// and clamping; the leak term follows the LMS_LEAK_EN macro.
module tb_lms_update_engine;

  localparam int W    = 16;
  localparam int FR   = 12;
  localparam int CW   = 18;
  localparam int CF   = 14;
  localparam int TAPS = 4;
  localparam int LEAK = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid;
  logic                 ready;
  logic [W-1:0]         err;
  logic [W-1:0]         step;
  logic [TAPS*W-1:0]    din;
  logic                 load;
  logic [TAPS*CW-1:0]   lw;
  logic [TAPS*CW-1:0]   weights;
  logic                 done;
  logic                 sat;

  int     vectors     = 0;
  int     miscompares = 0;
  longint mw [TAPS];
  bit     msat;

  always #5 clk = ~clk;

  lms_update_engine #(
    .WIDTH(W), .FRAC(FR), .COEFF_WIDTH(CW), .COEFF_FRAC(CF), .TAPS(TAPS), .LEAK_SHIFT(LEAK)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_error       (err),
    .i_step_size   (step),
    .i_din         (din),
    .i_load        (load),
    .i_load_weights(lw),
    .o_weights     (weights),
    .o_done        (done),
    .o_sat         (sat)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input int bits, output bit hit);
    longint hi, lo;
    hi  = (longint'(1) << (bits - 1)) - 1;
    lo  = -hi - 1;
    hit = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic logic [TAPS*CW-1:0] pack_w();
    logic [TAPS*CW-1:0] r;
    for (int k = 0; k < TAPS; k++) r[k*CW +: CW] = CW'(mw[k]);
    return r;
  endfunction

  function automatic logic [TAPS*W-1:0] pack_x(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic model_update(input logic [W-1:0] e, input logic [W-1:0] mu,
                              input logic [TAPS*W-1:0] x);
    longint ev, muv, mue, xv, off, sum;
    bit     hit;
    ev   = longint'($signed(e));
    muv  = longint'($signed(mu));
    msat = 1'b0;
    mue  = clamp(floor_div(muv * ev, longint'(1) << FR), W, hit);
    if (hit) msat = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      xv  = longint'($signed(x[k*W +: W]));
      off = clamp(floor_div(xv * mue, longint'(1) << (2 * FR - CF - 1)), CW, hit);
      if (hit) msat = 1'b1;
      sum = mw[k] + off;
`ifdef LMS_LEAK_EN
      sum = sum - floor_div(mw[k], longint'(1) << LEAK);
`endif
      mw[k] = clamp(sum, CW, hit);
      if (hit) msat = 1'b1;
    end
  endtask

  // Called at posedge+1 in idle; returns at posedge+1.
  task automatic do_load(input logic [TAPS*CW-1:0] value, input bit with_valid);
    int dcnt;
    load  = 1'b1;
    valid = with_valid;
    lw    = value;
    #1;
    check("load_ready_low", ready, 0);
    @(posedge clk); #1;
    load  = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < TAPS; k++) mw[k] = longint'($signed(value[k*CW +: CW]));
    check("load_weights", weights, pack_w());
    dcnt = 0;
    if (with_valid) begin
      repeat (10) begin
        if (done) dcnt++;
        @(posedge clk); #1;
      end
      check("load_no_done", dcnt, 0);
      check("load_no_accept_ready", ready, 1);
    end
  endtask

  task automatic run_update(input logic [W-1:0] e, input logic [W-1:0] mu,
                            input logic [TAPS*W-1:0] x, input bit busy, input int rst_at);
    logic [TAPS*CW-1:0] old_w, new_w, mix;
    int dcnt, dcyc;
    old_w = pack_w();
    if (rst_at == 0) begin
      model_update(e, mu, x);
    end else begin
      for (int k = 0; k < TAPS; k++) mw[k] = 0;
      msat = 1'b0;
    end
    new_w = pack_w();
    err   = e;
    step  = mu;
    din   = x;
    valid = 1'b1;
    @(posedge clk); #1;
    dcnt = 0;
    dcyc = -1;
    for (int c = 1; c <= 12; c++) begin
      valid = busy && (c <= 7);
      load  = busy && (c <= 7);
      if (busy) begin
        err  = W'($urandom);
        step = W'($urandom);
        din  = {$urandom, $urandom};
        lw   = {$urandom, $urandom, $urandom};
      end
      if (c == rst_at) rst = 1'b1;
      #1;
      if (c == 1) check("sat_cleared_on_accept", sat, 0);
      if (rst_at == 0) begin
        if (c <= 7) check("busy_ready_low", ready, 0);
        if (c >= 3 && c <= 7) begin
          mix = old_w;
          for (int k = 0; k < TAPS; k++)
            if (c >= k + 4) mix[k*CW +: CW] = new_w[k*CW +: CW];
          check("partial_weights", weights, mix);
        end
        if (c == 8) check("ready_with_done", ready, 1);
      end else if (c == rst_at + 1) begin
        check("reset_weights_zero", weights, 0);
        check("reset_ready", ready, 1);
      end
      if (done) begin
        dcnt++;
        if (dcyc < 0) dcyc = c;
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
    if (rst_at == 0) begin
      check("done_count", dcnt, 1);
      check("done_cycle", dcyc, 8);
    end else begin
      check("no_done_after_reset", dcnt, 0);
    end
    check("final_weights", weights, new_w);
    check("final_sat", sat, msat);
  endtask

  initial begin
    logic [TAPS*CW-1:0] exp_w;
    logic [W-1:0]       re, rmu;
    rst   = 1'b1;
    valid = 1'b0;
    load  = 1'b0;
    err   = '0;
    step  = '0;
    din   = '0;
    lw    = '0;
    for (int k = 0; k < TAPS; k++) mw[k] = 0;
    msat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_sat", sat, 0);
    check("reset_weights", weights, 0);

    // Basic update
    run_update(16'd2048, 16'd1024, pack_x(4096, -4096, 2048, 0), 1'b0, 0);
    exp_w = {18'sd0, 18'sd2048, -18'sd4096, 18'sd4096};
    check("basic_weights_const", weights, exp_w);
    check("basic_sat_const", sat, 0);

    // Saturation: bank at positive full scale
    exp_w = {4{18'sd131071}};
    do_load(exp_w, 1'b0);
    run_update(16'd4096, 16'd4096, pack_x(4096, 4096, 4096, 4096), 1'b0, 0);
    check("sat_weights_const", weights, exp_w);
    check("sat_flag_const", sat, 1);
    repeat (3) @(posedge clk);
    #1;
    check("sat_flag_sticky", sat, 1);

    // Busy: new requests, operands and loads during the update are ignored
    do_load('0, 1'b0);
    run_update(16'd2048, 16'd1024, pack_x(4096, -4096, 2048, 0), 1'b1, 0);
    exp_w = {18'sd0, 18'sd2048, -18'sd4096, 18'sd4096};
    check("busy_weights_const", weights, exp_w);

    // Reset in the middle of an update
    do_load('0, 1'b0);
    run_update(16'd2048, 16'd1024, pack_x(4096, -4096, 2048, 0), 1'b0, 4);

    // Load has priority over a simultaneous request
    do_load({$urandom, $urandom, $urandom}, 1'b1);

    // Zero error: only leakage (if built in) changes the bank
    exp_w = {4{18'sd16384}};
    do_load(exp_w, 1'b0);
    run_update(16'd0, W'($urandom), {$urandom, $urandom}, 1'b0, 0);
`ifdef LMS_LEAK_EN
    exp_w = {4{18'sd15360}};
`endif
    check("leak_weights_const", weights, exp_w);

    // Randomized updates against the model
    for (int r = 0; r < 12; r++) begin
      if (r % 2 == 0) do_load({$urandom, $urandom, $urandom}, 1'b0);
      if (r % 3 == 0) begin
        re  = W'($urandom);
        rmu = W'($urandom);
      end else begin
        re  = W'($urandom_range(8191) - 4096);
        rmu = W'($urandom_range(8191) - 4096);
      end
      run_update(re, rmu, {$urandom, $urandom}, r % 4 == 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
